// File: rtl/rr_arb_pkg.sv
// Shared definitions for the round-robin select arbiter.
//   NUM_REQ     : requester count, fixed at 8 to match the 3-bit decoder index
//   IDX_W       : width of the grant index driven to the 3:8 decoder
//   arb_state_t : arbiter FSM states (IDLE, GRANT)
package rr_arb_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Finds the first set request bit when searching ptr, ptr+1, ..., ptr+7 (mod 8).
// Ports:
//   req   in  [NUM_REQ-1:0] request vector
//   ptr   in  [IDX_W-1:0]   highest-priority index
//   idx   out [IDX_W-1:0]   winning requester index (valid when found=1)
//   found out               at least one request is set
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [IDX_W-1:0]     w_off;

  // Rotate so that requester ptr lands at bit 0, then take the lowest set bit.
  always_comb begin
    w_dbl = {req, req};
    w_rot = NUM_REQ'(w_dbl >> ptr);
    w_off = {IDX_W{1'b0}};
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off = IDX_W'(i);
      end else begin
        w_off = w_off;
      end
    end
  end

  // Undo the rotation; the 3-bit sum wraps naturally modulo 8.
  assign idx   = w_off + ptr;
  assign found = |req;

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter over 8 requesters producing the registered grant index
// for a downstream 3:8 one-hot decoder. A grant is held until the owner pulses
// done or withdraws its request; priority then rotates to the index after the
// owner. Every release is followed by at least one IDLE cycle with sel_valid=0.
// Optional feature macro: GRANT_TIMEOUT_EN (adds TIMEOUT parameter, grant-length
// counter and the timeout output pulse on a forced release).
// Ports:
//   clk       in       sole clock, posedge
//   rst       in       synchronous active-high reset
//   req       in  [7:0] request vector
//   done      in       completion pulse from the current owner
//   sel       out [2:0] registered grant index (decoder input)
//   sel_valid out       sel is a live grant
//   busy      out       arbiter is in GRANT
//   timeout   out       forced-release pulse (GRANT_TIMEOUT_EN only)
module rr_select_arbiter
  import rr_arb_pkg::*;
`ifdef GRANT_TIMEOUT_EN
#(
  parameter int TIMEOUT = 16
)
`endif
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [IDX_W-1:0]   sel,
  output logic               sel_valid,
`ifdef GRANT_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic               busy
);

  arb_state_t         r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_sel, w_sel_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic               r_sel_valid, w_valid_nxt;
  logic               r_busy, w_busy_nxt;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_found;
  logic               w_release;
  logic               w_force_rel;

  rr_pick u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .idx   (w_pick_idx),
    .found (w_pick_found)
  );

  // done and owner withdrawal in the same cycle collapse into one release.
  assign w_release = done | ~req[r_sel];

`ifdef GRANT_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt, w_cnt_nxt;
  logic       r_timeout, w_timeout_nxt;

  // A normal release takes precedence, so the forced path only fires without one.
  assign w_force_rel = (r_state == GRANT) && !w_release && (r_cnt == TMO_LAST);

  // Grant-length counter: cleared on grant entry, counts every GRANT cycle.
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_timeout_nxt = 1'b0;
    if (r_state == GRANT) begin
      w_cnt_nxt     = r_cnt + 8'd1;
      w_timeout_nxt = w_force_rel;
    end else begin
      if (w_pick_found) begin
        w_cnt_nxt = 8'd0;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end
  end

  // Counter and timeout pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_force_rel = 1'b0;
`endif

  // FSM next-state and registered-output next values.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_ptr_nxt   = r_ptr;
    w_valid_nxt = r_sel_valid;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (w_pick_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end else begin
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        if (w_release || w_force_rel) begin
          // sel is kept; only the priority pointer moves past the owner.
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_sel + 3'd1;
        end else begin
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sel       <= 3'd0;
      r_ptr       <= 3'd0;
      r_sel_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_ptr       <= w_ptr_nxt;
      r_sel_valid <= w_valid_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign sel       = r_sel;
  assign sel_valid = r_sel_valid;
  assign busy      = r_busy;

endmodule
